// File: rtl/tc_operand_addrgen.sv
// Tensor-core operand buffer read-address generator with precision re-reads.
// Optional ping-pong bank select is enabled by defining ADDRGEN_PINGPONG_EN.
module tc_operand_addrgen #(
   parameter int ADDR_W = 4,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   input  logic [LEN_W-1:0]  len,
   input  logic              ready,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rdaddr,
   output logic [2:0]        sub_idx,
   output logic              last,
   output logic              bank_sel,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_RUN  = 3'b010,
      S_DONE = 3'b100
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        mode_q;
   logic [ADDR_W-1:0] stride_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  wcnt_q, wcnt_d;
   logic [2:0]        sub_q, sub_d;
   logic [2:0]        pack_m1;
   logic              capture;
   logic              accept;
   logic              sub_end;
   logic              word_end;

   assign capture  = start & (state_q != S_RUN);
   assign accept   = (state_q == S_RUN) & ready;
   assign sub_end  = (sub_q == pack_m1);
   assign word_end = (wcnt_q == len_q - LEN_W'(1));

   always_comb begin
      case (mode_q)
         2'b00:   pack_m1 = 3'd0;
         2'b01:   pack_m1 = 3'd1;
         2'b10:   pack_m1 = 3'd3;
         default: pack_m1 = 3'd7;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = (len != '0) ? S_RUN : S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (accept && word_end && sub_end) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // output decode
   always_comb begin
      rd_en = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      last  = 1'b0;
      case (state_q)
         S_RUN: begin
            rd_en = 1'b1;
            busy  = 1'b1;
            last  = word_end & sub_end;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // word/sub-element walk; address only reloads when a real tile starts
   always_comb begin
      addr_d = addr_q;
      sub_d  = sub_q;
      wcnt_d = wcnt_q;
      if (capture && (len != '0)) begin
         addr_d = base_addr;
         sub_d  = 3'd0;
         wcnt_d = '0;
      end else if (accept) begin
         if (sub_end) begin
            sub_d  = 3'd0;
            addr_d = addr_q + stride_q;
            wcnt_d = wcnt_q + LEN_W'(1);
         end else begin
            sub_d  = sub_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q   <= '0;
         stride_q <= '0;
         len_q    <= '0;
         addr_q   <= '0;
         sub_q    <= '0;
         wcnt_q   <= '0;
      end else begin
         addr_q <= addr_d;
         sub_q  <= sub_d;
         wcnt_q <= wcnt_d;
         if (capture) begin
            mode_q   <= mode;
            stride_q <= stride;
            len_q    <= len;
         end
      end
   end

   assign rdaddr  = addr_q;
   assign sub_idx = sub_q;

`ifdef ADDRGEN_PINGPONG_EN
   logic bank_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         bank_q <= 1'b0;
      end else if (state_d == S_DONE) begin
         bank_q <= ~bank_q;
      end
   end

   assign bank_sel = bank_q;
`else
   assign bank_sel = 1'b0;
`endif

endmodule

// File: tb/tb_tc_operand_addrgen.sv
// Randomized self-checking bench for tc_operand_addrgen.
// Expected beats come from a tile-level model built with plain loops.
module tb_tc_operand_addrgen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic [3:0] base_addr;
   logic [3:0] stride;
   logic [4:0] len;
   logic       ready;
   logic       rd_en;
   logic [3:0] rdaddr;
   logic [2:0] sub_idx;
   logic       last;
   logic       bank_sel;
   logic       busy;
   logic       done;

`ifdef ADDRGEN_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   bit exp_bank = 1'b0;
   int q_addr[$];
   int q_sub[$];

   tc_operand_addrgen #(.ADDR_W(4), .LEN_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .base_addr (base_addr),
      .stride    (stride),
      .len       (len),
      .ready     (ready),
      .rd_en     (rd_en),
      .rdaddr    (rdaddr),
      .sub_idx   (sub_idx),
      .last      (last),
      .bank_sel  (bank_sel),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // every beat of a tile: word w at base + w*stride, each re-read PACK times
   function automatic void model_tile(input int m, input int b, input int s, input int l);
      int pack;
      pack = 1 << m;
      q_addr.delete();
      q_sub.delete();
      for (int w = 0; w < l; w++) begin
         for (int k = 0; k < pack; k++) begin
            q_addr.push_back((b + w * s) % 16);
            q_sub.push_back(k);
         end
      end
   endfunction

   task automatic launch(input int m, input int b, input int s, input int l);
      mode      = 2'(m);
      base_addr = 4'(b);
      stride    = 4'(s);
      len       = 5'(l);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      mode      = 2'($urandom);
      base_addr = 4'($urandom);
      stride    = 4'($urandom);
      len       = 5'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({rd_en, busy, done, last, bank_sel, rdaddr, sub_idx} !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 000",
                  {rd_en, busy, done, last, bank_sel, rdaddr, sub_idx});
      end
      rst = 1'b1;
      exp_bank = 1'b0;
      @(negedge clk);
      checks++;
      if ({rd_en, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_idle got %b exp 000", {rd_en, busy, done});
      end
   endtask

   task automatic test_tiles();
      int m, b, s, l, cyc;
      for (int t = 0; t < 16; t++) begin
         case (t)
            0: begin m = 0; b = 2;  s = 1;  l = 4;  end
            1: begin m = 3; b = 0;  s = 1;  l = 2;  end
            2: begin m = 1; b = 14; s = 3;  l = 3;  end
            3: begin m = 0; b = 15; s = 15; l = 16; end
            4: begin m = 2; b = 6;  s = 0;  l = 3;  end
            default: begin
               m = $urandom_range(0, 3);
               b = $urandom_range(0, 15);
               s = $urandom_range(0, 15);
               l = $urandom_range(0, 6);
            end
         endcase
         model_tile(m, b, s, l);
         ready = 1'b1;
         launch(m, b, s, l);
         cyc = 0;
         while (q_addr.size() != 0 && cyc < 300) begin
            checks++;
            if ({rd_en, busy, done, last, bank_sel, rdaddr, sub_idx} !==
                {3'b110, q_addr.size() == 1, exp_bank, 4'(q_addr[0]), 3'(q_sub[0])}) begin
               errors++;
               $display("FAIL tile%0d_beat got en%b bsy%b dn%b lst%b bk%b a%0d s%0d exp addr%0d sub%0d last%0d",
                        t, rd_en, busy, done, last, bank_sel, rdaddr, sub_idx,
                        q_addr[0], q_sub[0], q_addr.size() == 1);
            end
            ready = (t < 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (ready) begin
               void'(q_addr.pop_front());
               void'(q_sub.pop_front());
            end
            @(negedge clk);
            cyc++;
         end
         checks++;
         if (cyc >= 300) begin
            errors++;
            $display("FAIL tile%0d_timeout got %0d cycles exp <300", t, cyc);
         end
         ready = 1'b1;
         exp_bank ^= PP;
         checks++;
         if ({rd_en, busy, done, bank_sel} !== {3'b001, exp_bank}) begin
            errors++;
            $display("FAIL tile%0d_done got %b exp %b", t,
                     {rd_en, busy, done, bank_sel}, {3'b001, exp_bank});
         end
         @(negedge clk);
         checks++;
         if ({rd_en, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL tile%0d_idle got %b exp 000", t, {rd_en, busy, done});
         end
      end
   endtask

   task automatic test_stall();
      ready = 1'b1;
      launch(2, 5, 2, 1);
      checks++;
      if ({rd_en, rdaddr, sub_idx, last} !== {1'b1, 4'd5, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL stall_beat1 got a%0d s%0d l%b", rdaddr, sub_idx, last);
      end
      @(negedge clk);
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rd_en, busy, rdaddr, sub_idx, last} !== {2'b11, 4'd5, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold%0d got en%b a%0d s%0d l%b exp en1 a5 s1 l0",
                     i, rd_en, rdaddr, sub_idx, last);
         end
         if (i == 3) ready = 1'b1;
         else @(negedge clk);
      end
      for (int k = 2; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if ({rd_en, rdaddr, sub_idx, last} !== {1'b1, 4'd5, 3'(k), k == 3}) begin
            errors++;
            $display("FAIL stall_beat%0d got a%0d s%0d l%b", k + 1, rdaddr, sub_idx, last);
         end
      end
      @(negedge clk);
      exp_bank ^= PP;
      checks++;
      if ({rd_en, done, bank_sel} !== {2'b01, exp_bank}) begin
         errors++;
         $display("FAIL stall_done got %b exp %b", {rd_en, done, bank_sel}, {2'b01, exp_bank});
      end
      @(negedge clk);
   endtask

   task automatic test_len0();
      launch(0, 9, 1, 0);
      exp_bank ^= PP;
      checks++;
      if ({rd_en, busy, done, bank_sel} !== {3'b001, exp_bank}) begin
         errors++;
         $display("FAIL len0_done got %b exp %b", {rd_en, busy, done, bank_sel}, {3'b001, exp_bank});
      end
      @(negedge clk);
      checks++;
      if ({rd_en, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL len0_idle got %b exp 000", {rd_en, busy, done});
      end
   endtask

   task automatic test_start_during_run();
      int beats;
      bit seen_done;
      ready = 1'b1;
      model_tile(1, 4, 5, 2);
      launch(1, 4, 5, 2);
      start = 1'b1;
      mode = 2'd3;
      base_addr = 4'd11;
      len = 5'd7;
      beats = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 20 && !seen_done; c++) begin
         if (c == 2) start = 1'b0;
         if (rd_en) begin
            beats++;
            checks++;
            if (q_addr.size() == 0) begin
               errors++;
               $display("FAIL ignore_start_extra got beat a%0d s%0d exp none", rdaddr, sub_idx);
            end else begin
               if ({rdaddr, sub_idx} !== {4'(q_addr[0]), 3'(q_sub[0])}) begin
                  errors++;
                  $display("FAIL ignore_start_beat got a%0d s%0d exp a%0d s%0d",
                           rdaddr, sub_idx, q_addr[0], q_sub[0]);
               end
               void'(q_addr.pop_front());
               void'(q_sub.pop_front());
            end
         end
         if (done) seen_done = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if ({seen_done, 8'(beats)} !== {1'b1, 8'd4}) begin
         errors++;
         $display("FAIL ignore_start_count got beats %0d done %b exp beats 4 done 1", beats, seen_done);
      end
      exp_bank ^= PP;
      checks++;
      if (bank_sel !== exp_bank) begin
         errors++;
         $display("FAIL ignore_start_bank got %b exp %b", bank_sel, exp_bank);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      ready = 1'b1;
      launch(0, 3, 1, 2);
      checks++;
      if ({rd_en, rdaddr, sub_idx, last} !== {1'b1, 4'd3, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL b2b_a1 got en%b a%0d s%0d l%b", rd_en, rdaddr, sub_idx, last);
      end
      @(negedge clk);
      checks++;
      if ({rd_en, rdaddr, sub_idx, last} !== {1'b1, 4'd4, 3'd0, 1'b1}) begin
         errors++;
         $display("FAIL b2b_a2 got en%b a%0d s%0d l%b", rd_en, rdaddr, sub_idx, last);
      end
      @(negedge clk);
      exp_bank ^= PP;
      checks++;
      if ({rd_en, done, bank_sel} !== {2'b01, exp_bank}) begin
         errors++;
         $display("FAIL b2b_done1 got %b exp %b", {rd_en, done, bank_sel}, {2'b01, exp_bank});
      end
      mode = 2'd0;
      base_addr = 4'd10;
      stride = 4'd1;
      len = 5'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({rd_en, busy, done, last, rdaddr, sub_idx} !== {4'b1101, 4'd10, 3'd0}) begin
         errors++;
         $display("FAIL b2b_b1 got en%b bsy%b dn%b l%b a%0d s%0d exp en1 bsy1 dn0 l1 a10 s0",
                  rd_en, busy, done, last, rdaddr, sub_idx);
      end
      @(negedge clk);
      exp_bank ^= PP;
      checks++;
      if ({rd_en, done, bank_sel} !== {2'b01, exp_bank}) begin
         errors++;
         $display("FAIL b2b_done2 got %b exp %b", {rd_en, done, bank_sel}, {2'b01, exp_bank});
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_tile();
      ready = 1'b1;
      launch(1, 7, 1, 4);
      repeat (2) @(negedge clk);
      checks++;
      if ({rd_en, rdaddr, sub_idx} !== {1'b1, 4'd8, 3'd0}) begin
         errors++;
         $display("FAIL rst_mid_beat3 got en%b a%0d s%0d exp en1 a8 s0", rd_en, rdaddr, sub_idx);
      end
      rst = 1'b0;
      @(negedge clk);
      exp_bank = 1'b0;
      checks++;
      if ({rd_en, busy, done, last, bank_sel, rdaddr, sub_idx} !== 12'h000) begin
         errors++;
         $display("FAIL rst_mid_outputs got %h exp 000",
                  {rd_en, busy, done, last, bank_sel, rdaddr, sub_idx});
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({rd_en, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid_no_done got %b exp 000", {rd_en, busy, done});
      end
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      ready = 1'b1;
      mode = 2'd0;
      base_addr = 4'd0;
      stride = 4'd0;
      len = 5'd0;
      test_reset();
      test_tiles();
      test_stall();
      test_len0();
      test_start_during_run();
      test_back_to_back();
      test_reset_mid_tile();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
